// File: rtl/scalar_mult_sequencer.sv
// Left-to-right double-and-add controller. Point arithmetic is done by an external unit.
// Define SKM_FAST_SCAN_EN to find the scalar MSB in one cycle; otherwise SCAN steps one bit per cycle.
module scalar_mult_sequencer #(
   parameter int NUM_BITS = 163,
   parameter int K_BITS   = 163
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS:0]   x,
   input  logic [NUM_BITS:0]   y,
   input  logic [K_BITS-1:0]   k,
   output logic [NUM_BITS:0]   SkX,
   output logic [NUM_BITS:0]   SkY,
   output logic                inf,
   output logic                busy,
   output logic                done,
   output logic                op_start,
   output logic                op_sel,
   output logic [NUM_BITS:0]   op_ax,
   output logic [NUM_BITS:0]   op_ay,
   output logic [NUM_BITS:0]   op_bx,
   output logic [NUM_BITS:0]   op_by,
   input  logic                op_done,
   input  logic                op_rinf,
   input  logic [NUM_BITS:0]   op_rx,
   input  logic [NUM_BITS:0]   op_ry
);

   localparam int IW = (K_BITS > 1) ? $clog2(K_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT, FIN
   } state_t;

   typedef logic [NUM_BITS:0] coord_t;
   typedef logic [IW-1:0]     idx_t;

   localparam idx_t IDX_TOP = idx_t'(K_BITS - 1);

   state_t            state, state_nx;
   coord_t            p_x, p_y, p_x_nx, p_y_nx;
   coord_t            q_x, q_y, q_x_nx, q_y_nx;
   logic              q_inf, q_inf_nx;
   logic [K_BITS-1:0] k_r, k_nx;
   idx_t              idx, idx_nx;
   logic              issue, issue_add;
   logic              p_zero;
   logic              result_ok;

   assign p_zero = (p_x == '0) && (p_y == '0);
   // op_start is high only in the first WAIT cycle, so a same-cycle op_done cannot belong to this op.
   assign result_ok = op_done && !op_start;

`ifdef SKM_FAST_SCAN_EN
   function automatic idx_t msb_index(input logic [K_BITS-1:0] v);
      msb_index = '0;
      for (int b = 0; b < K_BITS; b++)
         if (v[b]) msb_index = idx_t'(b);
   endfunction
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_nx  = state;
      p_x_nx    = p_x;
      p_y_nx    = p_y;
      k_nx      = k_r;
      idx_nx    = idx;
      q_x_nx    = q_x;
      q_y_nx    = q_y;
      q_inf_nx  = q_inf;
      issue     = 1'b0;
      issue_add = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               p_x_nx   = x;
               p_y_nx   = y;
               k_nx     = k;
               idx_nx   = IDX_TOP;
               q_inf_nx = 1'b1;
               state_nx = SCAN;
            end
         end

         SCAN: begin
`ifdef SKM_FAST_SCAN_EN
            if (k_r == '0 || p_zero) begin
               state_nx = FIN;
            end else begin
               q_x_nx   = p_x;
               q_y_nx   = p_y;
               q_inf_nx = 1'b0;
               idx_nx   = msb_index(k_r);
               state_nx = NEXT;
            end
`else
            if (p_zero) begin
               state_nx = FIN;
            end else if (k_r[idx]) begin
               q_x_nx   = p_x;
               q_y_nx   = p_y;
               q_inf_nx = 1'b0;
               state_nx = NEXT;
            end else if (idx == '0) begin
               state_nx = FIN;
            end else begin
               idx_nx = idx - idx_t'(1);
            end
`endif
         end

         NEXT: begin
            if (idx == '0) begin
               state_nx = FIN;
            end else begin
               idx_nx   = idx - idx_t'(1);
               state_nx = DBL;
            end
         end

         DBL: begin
            // Doubling infinity is infinity, so no op is needed.
            if (q_inf) begin
               state_nx = k_r[idx] ? ADD : NEXT;
            end else begin
               issue    = 1'b1;
               state_nx = DBL_WAIT;
            end
         end

         DBL_WAIT: begin
            if (result_ok) begin
               q_x_nx   = op_rx;
               q_y_nx   = op_ry;
               q_inf_nx = op_rinf;
               state_nx = k_r[idx] ? ADD : NEXT;
            end
         end

         ADD: begin
            if (q_inf) begin
               q_x_nx   = p_x;
               q_y_nx   = p_y;
               q_inf_nx = 1'b0;
               state_nx = NEXT;
            end else begin
               issue     = 1'b1;
               issue_add = 1'b1;
               state_nx  = ADD_WAIT;
            end
         end

         ADD_WAIT: begin
            if (result_ok) begin
               q_x_nx   = op_rx;
               q_y_nx   = op_ry;
               q_inf_nx = op_rinf;
               state_nx = NEXT;
            end
         end

         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         p_x      <= '0;
         p_y      <= '0;
         q_x      <= '0;
         q_y      <= '0;
         q_inf    <= 1'b0;
         k_r      <= '0;
         idx      <= '0;
         SkX      <= '0;
         SkY      <= '0;
         inf      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         op_start <= 1'b0;
         op_sel   <= 1'b0;
         op_ax    <= '0;
         op_ay    <= '0;
         op_bx    <= '0;
         op_by    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state    <= state_nx;
         p_x      <= p_x_nx;
         p_y      <= p_y_nx;
         q_x      <= q_x_nx;
         q_y      <= q_y_nx;
         q_inf    <= q_inf_nx;
         k_r      <= k_nx;
         idx      <= idx_nx;
         busy     <= (state_nx != IDLE);
         done     <= (state_nx == FIN);
         op_start <= issue;

         // Operands stay put after issue until the next op is launched.
         if (issue) begin
            op_sel <= issue_add;
            op_ax  <= q_x;
            op_ay  <= q_y;
            op_bx  <= p_x;
            op_by  <= p_y;
         end

         if (state_nx == FIN) begin
            SkX <= q_inf ? '0 : q_x;
            SkY <= q_inf ? '0 : q_y;
            inf <= q_inf;
         end
      end
   end

endmodule

// File: tb/tb_scalar_mult_sequencer.sv
// Bench for scalar_mult_sequencer: the op unit is modelled as the group (Z/2^W)^2, so kP = (k*x, k*y).
// Works with or without SKM_FAST_SCAN_EN.
module tb_scalar_mult_sequencer;

   localparam int NB    = 163;
   localparam int KB    = 163;
   localparam int W     = NB + 1;
   localparam int LIMIT = 8000;
`ifdef SKM_FAST_SCAN_EN
   localparam int K0_LAT = 2;
`else
   localparam int K0_LAT = KB + 1;
`endif

   typedef logic [W-1:0]  w_t;
   typedef logic [KB-1:0] k_t;

   typedef struct {
      w_t    px;
      w_t    py;
      k_t    kk;
      logic  e_inf;
      int    e_ops;
      string name;
   } vec_t;

   typedef struct {
      w_t   x;
      w_t   y;
      logic inf;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic start = 1'b0;
   w_t   x = '0, y = '0;
   k_t   k = '0;
   w_t   SkX, SkY;
   logic inf, busy, done, op_start, op_sel;
   w_t   op_ax, op_ay, op_bx, op_by;
   logic op_done = 1'b0, op_rinf = 1'b0;
   w_t   op_rx = '0, op_ry = '0;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic op_log[$];
   int   op_count = 0;
   logic pending = 1'b0;
   logic force_rinf = 1'b0;

   always #5 clk = ~clk;

   scalar_mult_sequencer #(.NUM_BITS(NB), .K_BITS(KB)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .x(x), .y(y), .k(k),
      .SkX(SkX), .SkY(SkY), .inf(inf), .busy(busy), .done(done),
      .op_start(op_start), .op_sel(op_sel),
      .op_ax(op_ax), .op_ay(op_ay), .op_bx(op_bx), .op_by(op_by),
      .op_done(op_done), .op_rinf(op_rinf), .op_rx(op_rx), .op_ry(op_ry)
   );

   task automatic check(input string name, input w_t act, input w_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Point unit model: dbl = 2A, add = A+B, result valid 3 cycles after op_start.
   int   op_cnt = 0;
   w_t   res_x, res_y;
   logic res_inf;
   always @(negedge clk) begin
      if (op_start === 1'b1)
         check("op_no_overlap", w_t'(pending), '0);
      if (op_cnt > 0) begin
         op_cnt--;
         if (op_cnt == 0) begin
            op_done = 1'b1;
            op_rx   = res_x;
            op_ry   = res_y;
            op_rinf = res_inf;
            pending = 1'b0;
         end
      end else begin
         op_done = 1'b0;
         op_rinf = 1'b0;
         op_rx   = ~res_x;
         op_ry   = ~res_y;
      end
      if (op_start === 1'b1) begin
         op_log.push_back(op_sel);
         op_count++;
         res_x = op_sel ? op_ax + op_bx : op_ax << 1;
         res_y = op_sel ? op_ay + op_by : op_ay << 1;
         if (force_rinf) begin
            res_x = '0;
            res_y = '0;
            res_inf = 1'b1;
            force_rinf = 1'b0;
         end else begin
            res_inf = (res_x == '0) && (res_y == '0);
         end
         pending = 1'b1;
         op_cnt  = 3;
      end
   end

   // Scoreboard: each done pops one expectation.
   exp_t mon_e;
   always @(negedge clk) begin
      if (n_rst && done === 1'b1) begin
         check("done_expected", w_t'(sb.size() > 0), w_t'(1));
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("skx", SkX, mon_e.x);
            check("sky", SkY, mon_e.y);
            check("inf", w_t'(inf), w_t'(mon_e.inf));
         end
      end
   end

   function automatic int exp_ops(input k_t kk);
      int m = -1;
      int pc = 0;
      for (int j = 0; j < KB; j++)
         if (kk[j]) begin
            m = j;
            pc++;
         end
      return (m < 0) ? 0 : m + pc - 1;
   endfunction

   function automatic w_t rand_odd();
      w_t r;
      for (int j = 0; j < W; j++) r[j] = 1'($urandom_range(0, 1));
      r[0] = 1'b1;
      return r;
   endfunction

   task automatic push_exp(input w_t ex, input w_t ey, input logic ei);
      exp_t e;
      e.x = ex;
      e.y = ey;
      e.inf = ei;
      sb.push_back(e);
   endtask

   task automatic launch(input w_t px, input w_t py, input k_t kk);
      x = px;
      y = py;
      k = kk;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x = ~px;
      y = ~py;
      k = ~kk;
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_done_seen"}, w_t'(done), w_t'(1));
   endtask

   task automatic run_vec(input w_t px, input w_t py, input k_t kk, input logic e_inf,
                          input int e_ops, input string name, output int lat);
      int ops0;
      ops0 = op_count;
      push_exp(px * w_t'(kk), py * w_t'(kk), e_inf);
      launch(px, py, kk);
      wait_done(name, lat);
      @(negedge clk);
      check({name, "_ops"}, w_t'(op_count - ops0), w_t'(e_ops));
   endtask

   initial begin
      vec_t vecs[9];
      w_t   pa, pb, pc, pd;
      k_t   kt;
      int   lat, n, ops0;
      logic sel0, sel1, sel2;

      pa = {36'h9_1234_5678, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3211};
      pb = {36'h0_0000_00a5, 64'h5a5a_5a5a_0f0f_0f0f, 64'h1357_9bdf_2468_ace1};
      pc = rand_odd();
      pd = rand_odd();
      kt = '0;
      kt[KB-1] = 1'b1;

      vecs[0] = '{px: pa, py: pb, kk: k_t'(5), e_inf: 1'b0, e_ops: 3, name: "k5"};
      vecs[1] = '{px: pb, py: pa, kk: k_t'(6), e_inf: 1'b0, e_ops: 3, name: "k6"};
      vecs[2] = '{px: pa, py: pb, kk: k_t'(1), e_inf: 1'b0, e_ops: 0, name: "k1"};
      vecs[3] = '{px: pc, py: pd, kk: k_t'(2), e_inf: 1'b0, e_ops: 1, name: "k2"};
      vecs[4] = '{px: '0, py: '0, kk: k_t'(7), e_inf: 1'b1, e_ops: 0, name: "p_inf"};
      vecs[5] = '{px: pa, py: pb, kk: kt, e_inf: 1'b0, e_ops: KB - 1, name: "k_top"};
      vecs[6] = '{px: pc, py: pb, kk: '1, e_inf: 1'b0, e_ops: 2 * (KB - 1), name: "k_ones"};
      for (int v = 7; v < 9; v++) begin
         for (int j = 0; j < KB; j++) kt[j] = 1'($urandom_range(0, 1));
         kt[0] = 1'b1;
         vecs[v] = '{px: rand_odd(), py: rand_odd(), kk: kt, e_inf: 1'b0,
                     e_ops: exp_ops(kt), name: "k_rand"};
      end

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_skx", SkX, '0);
      check("rst_busy", w_t'(busy), '0);
      check("rst_done", w_t'(done), '0);
      check("rst_op_start", w_t'(op_start), '0);
      n_rst = 1'b1;
      @(negedge clk);

      foreach (vecs[v]) begin
         run_vec(vecs[v].px, vecs[v].py, vecs[v].kk, vecs[v].e_inf, vecs[v].e_ops, vecs[v].name, lat);
         check({vecs[v].name, "_idle"}, w_t'(busy), '0);
      end

      // k = 0: infinity, no ops, scan latency.
      run_vec(pa, pb, '0, 1'b1, 0, "k0", lat);
      check("k0_latency", w_t'(lat), w_t'(K0_LAT));

      // Infinite result from the first doubling: the following add becomes Q = P.
      force_rinf = 1'b1;
      ops0 = op_count;
      push_exp(pa, pb, 1'b0);
      launch(pa, pb, k_t'(3));
      wait_done("rinf", lat);
      @(negedge clk);
      check("rinf_ops", w_t'(op_count - ops0), w_t'(1));

      // Start while busy is ignored; op order for k=5 is dbl, dbl, add.
      op_log.delete();
      ops0 = op_count;
      push_exp(pb * w_t'(5), pa * w_t'(5), 1'b0);
      launch(pb, pa, k_t'(5));
      repeat (3) @(negedge clk);
      x = pc;
      y = pd;
      k = k_t'(9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", lat);
      // Start in the FIN cycle (done=1) must also be ignored.
      x = pd;
      y = pc;
      k = k_t'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fin_start_ignored", w_t'(busy), '0);
      check("busy_start_ops", w_t'(op_count - ops0), w_t'(3));
      sel0 = (op_log.size() > 0) ? op_log[0] : 1'b1;
      sel1 = (op_log.size() > 1) ? op_log[1] : 1'b1;
      sel2 = (op_log.size() > 2) ? op_log[2] : 1'b0;
      check("k5_op_order", w_t'({sel0, sel1, sel2}), w_t'(3'b001));
      repeat (3) @(negedge clk);

      // Reset during ADD_WAIT abandons the run; the late op_done must be ignored.
      push_exp(pa * w_t'(5), pb * w_t'(5), 1'b0);
      launch(pa, pb, k_t'(5));
      n = 0;
      while (!(op_start === 1'b1 && op_sel === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_add_seen", w_t'(op_start && op_sel), w_t'(1));
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      sb.delete(sb.size() - 1);
      check("abort_busy", w_t'(busy), '0);
      check("abort_done", w_t'(done), '0);
      check("abort_skx", SkX, '0);
      check("abort_op_sel", w_t'(op_sel), '0);
      check("abort_op_ax", op_ax, '0);
      @(negedge clk);
      n_rst = 1'b1;
      n = 0;
      while (pending && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_op_drained", w_t'(pending), '0);
      repeat (3) @(negedge clk);
      check("abort_still_idle", w_t'(busy), '0);
      op_log.delete();
      run_vec(pb, pa, k_t'(2), 1'b0, 1, "after_abort", lat);
      sel0 = (op_log.size() > 0) ? op_log[0] : 1'b1;
      check("after_abort_dbl", w_t'(sel0), '0);

      repeat (5) @(negedge clk);
      check("sb_empty", w_t'(sb.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scalar_mult_sequencer.md
SCALAR_MULT_SEQUENCER -- requirements
Module: scalar_mult_sequencer

Interface
REQ-001 Parameter: NUM_BITS, 163, coordinate MSB index (coordinates are NUM_BITS+1 bits wide).
REQ-002 Parameter: K_BITS, 163, scalar width.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: n_rst  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  one-cycle request; samples x, y, k.
REQ-006 Port: x, y  in  NUM_BITS+1 each  affine base point P; (0,0) denotes infinity.
REQ-007 Port: k  in  K_BITS  scalar.
REQ-008 Port: SkX, SkY  out  NUM_BITS+1 each  result kP, registered.
REQ-009 Port: inf  out  1  result is the point at infinity.
REQ-010 Port: busy  out  1  operation in progress.
REQ-011 Port: done  out  1  one-cycle completion pulse.
REQ-012 Port: op_start  out  1  one-cycle request to the external point-arithmetic unit.
REQ-013 Port: op_sel  out  1  0 = double (A), 1 = add (A+B).
REQ-014 Port: op_ax, op_ay, op_bx, op_by  out  NUM_BITS+1 each  operands, held stable from op_start until op_done.
REQ-015 Port: op_done, op_rinf  in  1 each  result valid / result is infinity.
REQ-016 Port: op_rx, op_ry  in  NUM_BITS+1 each  result coordinates, valid when op_done=1.

Function
REQ-017 The block shall implement left-to-right double-and-add: Q=inf; for i=K_BITS-1 downto 0: Q=2Q; if k[i], Q=Q+P.
REQ-018 FSM states: IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT, FIN.
REQ-019 IDLE: start=1 latches P, k, and bit index i=K_BITS-1, sets Q=inf, busy=1, and goes to SCAN; start while busy shall be ignored.
REQ-020 SCAN: locates the highest set bit of k. k==0 or P==(0,0) -> FIN with inf=1. Otherwise Q=P, i=(highest set index), then NEXT.
REQ-021 NEXT: i==0 -> FIN; else decrement i -> DBL.
REQ-022 DBL: if Q is inf, skip to the add decision with no op issued. Else pulse op_start with op_sel=0 and A=Q -> DBL_WAIT.
REQ-023 DBL_WAIT: on op_done, load Q from op_rx/op_ry, Q.inf=op_rinf. Then go to ADD if k[i]=1, else NEXT.
REQ-024 ADD: if Q is inf, Q=P with no op issued -> NEXT. Else pulse op_start with op_sel=1, A=Q, B=P -> ADD_WAIT.
REQ-025 ADD_WAIT: on op_done, load Q and Q.inf=op_rinf -> NEXT.
REQ-026 FIN: SkX/SkY/inf take Q (coordinates forced to 0 when inf=1), done=1 for exactly one cycle, busy=0 -> IDLE.
REQ-027 Outputs SkX/SkY/inf shall hold until the next FIN.
REQ-028 op_start shall never assert while an op is outstanding. op_done outside a WAIT state shall be ignored.
REQ-029 start on the same cycle as FIN shall be ignored (busy is still 1).

Reset
REQ-030 n_rst=0 shall immediately force IDLE and clear: SkX, SkY, inf, busy, done, op_start, op_sel, and all operands to 0.
REQ-031 Reset mid-operation shall abandon the operation without issuing done. A late op_done after reset shall be ignored.

Configuration
REQ-032 Macro SKM_FAST_SCAN_EN defined: SCAN finds the highest set bit with a priority encoder in exactly 1 cycle.
REQ-033 Macro SKM_FAST_SCAN_EN undefined: SCAN shifts one bit per cycle from K_BITS-1, costing (K_BITS-1-msb)+1 cycles; k==0 costs K_BITS cycles. Results are identical in both builds.

Verification (op model asserts op_done 3 cycles after op_start)
REQ-034 k=5, P valid -> op sequence dbl, dbl, add (3 op_starts); done once; SkX/SkY equal a software model of 5P; inf=0.
REQ-035 k=0 -> no op_start; done with inf=1 and SkX=SkY=0. Latency: 2 cycles from start with SKM_FAST_SCAN_EN, K_BITS+1 without.
REQ-036 k=1 -> no op_start; SkX=x, SkY=y, inf=0.
REQ-037 k=3, op model returns op_rinf=1 on the first dbl -> next add issues no op, Q=P; done with SkX=x, SkY=y.
REQ-038 n_rst pulsed low during ADD_WAIT, then start with k=2 -> no done for the aborted run; new run issues exactly one dbl and completes.
REQ-039 start re-asserted while busy=1 with different k -> ignored; result matches the original k.
